// File: rtl/mac_seq_param.sv
// mac_seq_param: sequential signed multiply-accumulate engine.
// Computes the dot product of a TAPS-element window and kernel, LANES
// products per clock, into a full-precision accumulator. The final sum is
// scaled by an arithmetic right shift with round-half-up and then either
// saturated or truncated to NBITS.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-low reset
//   start   request, accepted on a rising edge while ready=1
//   inputs  packed signed window, element k at [k*NBITS +: NBITS]
//   weights packed signed kernel, same layout as inputs
//   ready   high when a start will be accepted (IDLE or DONE)
//   busy    high while accumulating (RUN)
//   P       registered signed result, held until the next result
//   done    one-cycle pulse in the first cycle a new P is valid
module mac_seq_param #(
   parameter int NBITS = 16,
   parameter int TAPS  = 9,
   parameter int LANES = 1,
   parameter int SHIFT = 0,
   parameter int SAT   = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [TAPS*NBITS-1:0]    inputs,
   input  logic [TAPS*NBITS-1:0]    weights,
   output logic                     ready,
   output logic                     busy,
   output logic signed [NBITS-1:0]  P,
   output logic                     done
);

   localparam int ACCW  = 2*NBITS + $clog2(TAPS);
   localparam int BEATS = (TAPS + LANES - 1) / LANES;
   localparam int PADW  = BEATS*LANES*NBITS;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

   // Rounding constant and clamp bounds, one bit wider than the
   // accumulator so adding the half-LSB can never wrap.
   localparam logic signed [ACCW:0] RND =
      (SHIFT > 0) ? ((ACCW+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
   localparam logic signed [ACCW:0] PMAX =
      {{(ACCW+2-NBITS){1'b0}}, {(NBITS-1){1'b1}}};
   localparam logic signed [ACCW:0] PMIN =
      {{(ACCW+2-NBITS){1'b1}}, {(NBITS-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                    state;
   // Operand copies are zero-padded to a whole number of beats and shifted
   // down by one beat each cycle, so lanes past the last tap read zero and
   // always multiply out to 0.
   logic [PADW-1:0]           in_r;
   logic [PADW-1:0]           wt_r;
   logic signed [ACCW-1:0]    acc;
   logic [CW-1:0]             cnt;

   logic signed [NBITS-1:0]   a;
   logic signed [NBITS-1:0]   b;
   logic signed [2*NBITS-1:0] prod;
   logic signed [ACCW-1:0]    beat_sum;
   logic signed [ACCW-1:0]    acc_next;
   logic signed [ACCW:0]      rsum;
   logic signed [ACCW:0]      shifted;
   logic signed [NBITS-1:0]   p_next;

   always_comb begin
      beat_sum = '0;
      a        = '0;
      b        = '0;
      prod     = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         a        = $signed(in_r[l*NBITS +: NBITS]);
         b        = $signed(wt_r[l*NBITS +: NBITS]);
         prod     = a * b;
         beat_sum = beat_sum + ACCW'(prod);
      end
   end

   assign acc_next = acc + beat_sum;
   assign rsum     = (ACCW+1)'(acc_next) + RND;
   assign shifted  = rsum >>> SHIFT;

   always_comb begin
      p_next = shifted[NBITS-1:0];
      if (SAT != 0) begin
         if (shifted > PMAX)
            p_next = PMAX[NBITS-1:0];
         else if (shifted < PMIN)
            p_next = PMIN[NBITS-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         in_r  <= '0;
         wt_r  <= '0;
         acc   <= '0;
         cnt   <= '0;
         P     <= '0;
         done  <= 1'b0;
         busy  <= 1'b0;
         ready <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            RUN: begin
               acc  <= acc_next;
               in_r <= in_r >> (LANES*NBITS);
               wt_r <= wt_r >> (LANES*NBITS);
               cnt  <= cnt + 1'b1;
               if (cnt == LAST) begin
                  P     <= p_next;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  ready <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               if (start) begin
                  in_r  <= PADW'(inputs);
                  wt_r  <= PADW'(weights);
                  acc   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  ready <= 1'b0;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_seq_param.sv
// tb_mac_seq_param: bench for mac_seq_param. Four instances with different
// LANES/SHIFT/SAT share one stimulus stream; a behavioural model (full dot
// product in plain integer arithmetic plus a beat countdown per instance)
// is compared with every output on every falling edge, and directed runs pin
// the model with hand-computed results and latencies.
module tb_mac_seq_param;

   localparam int NB = 16;
   localparam int NT = 9;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 start = 1'b0;
   logic [NT*NB-1:0]     inputs = '0;
   logic [NT*NB-1:0]     weights = '0;
   logic [3:0]           rdy;
   logic [3:0]           bsy;
   logic [3:0]           dn;
   logic signed [NB-1:0] p_o [4];

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;
   int lat [4];

   always #5 clk = ~clk;

   mac_seq_param #(.NBITS(16), .TAPS(9), .LANES(1), .SHIFT(0), .SAT(1)) u0 (
      .clk(clk), .reset(reset), .start(start), .inputs(inputs), .weights(weights),
      .ready(rdy[0]), .busy(bsy[0]), .P(p_o[0]), .done(dn[0]));
   mac_seq_param #(.NBITS(16), .TAPS(9), .LANES(4), .SHIFT(2), .SAT(1)) u1 (
      .clk(clk), .reset(reset), .start(start), .inputs(inputs), .weights(weights),
      .ready(rdy[1]), .busy(bsy[1]), .P(p_o[1]), .done(dn[1]));
   mac_seq_param #(.NBITS(16), .TAPS(9), .LANES(9), .SHIFT(0), .SAT(0)) u2 (
      .clk(clk), .reset(reset), .start(start), .inputs(inputs), .weights(weights),
      .ready(rdy[2]), .busy(bsy[2]), .P(p_o[2]), .done(dn[2]));
   mac_seq_param #(.NBITS(16), .TAPS(9), .LANES(2), .SHIFT(3), .SAT(0)) u3 (
      .clk(clk), .reset(reset), .start(start), .inputs(inputs), .weights(weights),
      .ready(rdy[3]), .busy(bsy[3]), .P(p_o[3]), .done(dn[3]));

   int ln [4] = '{1, 4, 9, 2};
   int sh [4] = '{0, 2, 0, 3};
   int st [4] = '{1, 1, 0, 0};

   // ---------------- reference model ----------------
   function automatic logic signed [15:0] mac_ref(input logic [143:0] x,
                                                  input logic [143:0] w,
                                                  input int shift, input int sat);
      longint acc;
      longint r;
      logic [63:0] rv;
      acc = 0;
      for (int k = 0; k < NT; k++)
         acc += longint'($signed(x[k*16 +: 16])) * longint'($signed(w[k*16 +: 16]));
      if (shift > 0) acc += longint'(1) << (shift - 1);
      r = acc >>> shift;
      if (sat != 0) begin
         if (r > 32767) r = 32767;
         if (r < -32768) r = -32768;
      end
      rv = r;
      return rv[15:0];
   endfunction

   bit                   m_busy [4];
   bit                   m_done [4];
   int                   m_cnt  [4];
   logic signed [15:0]   m_p    [4];
   logic signed [15:0]   m_pend [4];

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge reset) begin
      for (int i = 0; i < 4; i++) begin
         if (!reset) begin
            m_busy[i] <= 1'b0;
            m_done[i] <= 1'b0;
            m_cnt[i]  <= 0;
            m_p[i]    <= '0;
         end else if (m_busy[i]) begin
            m_cnt[i] <= m_cnt[i] - 1;
            if (m_cnt[i] == 1) begin
               m_busy[i] <= 1'b0;
               m_done[i] <= 1'b1;
               m_p[i]    <= m_pend[i];
            end else begin
               m_done[i] <= 1'b0;
            end
         end else begin
            m_done[i] <= 1'b0;
            if (start) begin
               m_busy[i] <= 1'b1;
               m_cnt[i]  <= (NT + ln[i] - 1) / ln[i];
               m_pend[i] <= mac_ref(inputs, weights, sh[i], st[i]);
            end
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string nm, input longint act, input longint exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("inst%0d ready", i), rdy[i], !m_busy[i]);
         chk($sformatf("inst%0d busy", i), bsy[i], m_busy[i]);
         chk($sformatf("inst%0d done", i), dn[i], m_done[i]);
         chk($sformatf("inst%0d P", i), p_o[i], m_p[i]);
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [143:0] fill(input int base, input int step);
      logic [143:0] r;
      r = '0;
      for (int k = 0; k < NT; k++) r[k*16 +: 16] = 16'(base + step*k);
      return r;
   endfunction

   function automatic logic [143:0] onehot(input int k);
      logic [143:0] r;
      r = '0;
      r[k*16 +: 16] = 16'd1;
      return r;
   endfunction

   function automatic logic [143:0] rnd_vec();
      logic [143:0] r;
      for (int k = 0; k < NT; k++) begin
         case ($urandom_range(0, 3))
            0:       r[k*16 +: 16] = 16'h7FFF;
            1:       r[k*16 +: 16] = 16'h8000;
            default: r[k*16 +: 16] = 16'($urandom);
         endcase
      end
      return r;
   endfunction

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (!(&rdy) && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("idle wait", &rdy, 1);
   endtask

   // One accepted operation; operands are scrambled right after accept.
   task automatic run_vec(input logic [143:0] x, input logic [143:0] w);
      int  e0;
      bit  seen [4];
      wait_idle();
      inputs  = x;
      weights = w;
      start   = 1'b1;
      @(negedge clk);
      e0      = cyc;
      start   = 1'b0;
      inputs  = ~x;
      weights = ~w;
      for (int i = 0; i < 4; i++) begin
         lat[i]  = -1;
         seen[i] = 1'b0;
      end
      for (int c = 0; c < 20; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (dn[i] && !seen[i]) begin
               seen[i] = 1'b1;
               lat[i]  = cyc - e0;
            end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL global timeout: simulation did not finish, got %0d checks", nchk);
      $fatal(1);
   end

   initial begin
      int cnt [4];
      int dsum;

      repeat (3) @(negedge clk);
      chk("reset P", p_o[0], 0);
      chk("reset done", dn, 0);
      chk("reset ready", rdy, 4'hF);
      chk("reset busy", bsy, 0);
      #2 reset = 1'b1;

      // 1..9 dot all-ones = 45
      run_vec(fill(1, 1), fill(1, 0));
      chk("A inst0 P", p_o[0], 45);
      chk("A inst1 P (shift2)", p_o[1], 11);
      chk("A inst2 P", p_o[2], 45);
      chk("A inst3 P (shift3)", p_o[3], 6);
      chk("A inst0 latency", lat[0], 9);
      chk("A inst1 latency", lat[1], 3);
      chk("A inst2 latency", lat[2], 1);
      chk("A inst3 latency", lat[3], 5);
      repeat (5) @(negedge clk);
      chk("A inst0 P held", p_o[0], 45);

      // full-scale positive
      run_vec(fill(32767, 0), fill(32767, 0));
      chk("B inst0 P sat", p_o[0], 32767);
      chk("B inst1 P sat", p_o[1], 32767);
      chk("B inst2 P trunc", p_o[2], 9);

      // full-scale negative
      run_vec(fill(-32768, 0), fill(32767, 0));
      chk("C inst0 P sat", p_o[0], -32768);

      // -45, rounds to -11
      run_vec(fill(1, 1), fill(-1, 0));
      chk("D inst0 P", p_o[0], -45);
      chk("D inst1 P", p_o[1], -11);

      // 6, rounds to 2
      run_vec(fill(1, 1), onehot(5));
      chk("E inst0 P", p_o[0], 6);
      chk("E inst1 P", p_o[1], 2);

      // start held high for 30 edges
      wait_idle();
      inputs  = fill(1, 1);
      weights = fill(1, 0);
      start   = 1'b1;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) cnt[i] += int'(dn[i]);
      end
      start = 1'b0;
      chk("held inst0 dones", cnt[0], 3);
      chk("held inst1 dones", cnt[1], 7);
      chk("held inst2 dones", cnt[2], 15);
      chk("held inst3 dones", cnt[3], 5);

      // reset after beat 4 of the LANES=1 run
      wait_idle();
      inputs  = fill(1, 1);
      weights = fill(1, 0);
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre-reset inst0 busy", bsy[0], 1);
      #2 reset = 1'b0;
      #1;
      chk("mid-run reset inst0 P", p_o[0], 0);
      chk("mid-run reset done", dn, 0);
      chk("mid-run reset ready", rdy, 4'hF);
      chk("mid-run reset busy", bsy, 0);
      @(negedge clk);
      #2 reset = 1'b1;
      dsum = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         dsum += int'(|dn);
      end
      chk("no done after reset release", dsum, 0);
      run_vec(fill(1, 1), fill(1, 0));
      chk("post-reset inst0 P", p_o[0], 45);
      chk("post-reset inst0 latency", lat[0], 9);

      // randomized traffic: random operands every cycle, sparse starts
      // (including during RUN) and occasional asynchronous resets
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         inputs  = rnd_vec();
         weights = rnd_vec();
         start   = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 99) == 0) begin
            #2 reset = 1'b0;
            @(negedge clk);
            #2 reset = 1'b1;
         end
      end
      start = 1'b0;
      wait_idle();
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule

// File: doc/mac_seq_param.md
# mac_seq_param

Parametrised sequential signed multiply-accumulate engine for the convolution datapath. It computes the dot product of a TAPS-element input window and a TAPS-element weight kernel, producing LANES products per clock. The accumulator is full-precision; the result is scaled by a right shift with round-half-up and then saturated or truncated to NBITS. It is the generalised successor of the fixed 9-tap, one-product-per-cycle MAC, and instances sit one per output pixel or channel inside the convolution array.

## Interface
Parameters:
- NBITS, 16: signed width of each input, weight and the result P.
- TAPS, 9: number of products per dot product; must be ≥ 1.
- LANES, 1: products accumulated per cycle; 1 ≤ LANES ≤ TAPS, need not divide TAPS.
- SHIFT, 0: arithmetic right shift applied to the accumulator before output; 0 ≤ SHIFT < ACCW.
- SAT, 1: 1 = saturate to the NBITS signed range; 0 = truncate to the low NBITS bits.
- Derived (localparam): ACCW = 2*NBITS + $clog2(TAPS); BEATS = ceil(TAPS/LANES).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  request; accepted on a rising edge when ready=1.
- inputs  in  TAPS*NBITS  packed signed window; element k occupies bits [k*NBITS +: NBITS].
- weights  in  TAPS*NBITS  packed signed kernel; same layout as inputs.
- ready  out  1  high when a start will be accepted (state IDLE or DONE).
- busy  out  1  high in RUN.
- P  out  NBITS  signed registered result; holds its value until the next result.
- done  out  1  one-cycle pulse marking the cycle in which a new P is first valid.

## Operation
- States: IDLE, RUN, DONE.
  - IDLE to RUN on an accepted start.
  - RUN to DONE after the last beat.
  - DONE to RUN if start is high; otherwise DONE to IDLE.
- On accept:
  - inputs and weights are captured into internal registers; later changes on the ports have no effect on the operation in flight.
  - The accumulator and the beat counter are cleared.
- RUN beat b (0..BEATS-1) adds the products for taps k = b*LANES .. min(b*LANES+LANES, TAPS)-1. On the final partial beat, unused lanes contribute 0.
- Arithmetic:
  - Each product is a full 2*NBITS signed value.
  - Products are sign-extended to ACCW before summation.
  - The accumulator cannot overflow.
- Output scaling, applied when leaving RUN:
  - r = (acc + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT, an arithmetic shift, so negative halves round toward +inf.
  - SAT=1: P = clamp(r, -2^(NBITS-1), 2^(NBITS-1)-1).
  - SAT=0: P = r[NBITS-1:0].
- A start while busy=1 is ignored. It is neither queued nor an error.
- Reset asserted at any time, including mid-RUN:
  - Immediately forces state IDLE, accumulator and counter 0, P=0, done=0, busy=0, ready=1.
  - No done pulse follows the release of reset.

## Timing
- Reset values: P=0, done=0, busy=0, ready=1.
- Accept edge E0, where start=1 and ready=1: busy=1 from the cycle after E0.
- Edges E1..E_BEATS each perform one beat.
- At edge E_BEATS, P is loaded with the scaled final sum, which includes the last beat's products. The state becomes DONE and done=1 for exactly that one cycle.
- Latency from accept edge to done high is BEATS cycles. With TAPS=9: LANES=1 gives 9 cycles; LANES=4 gives 3; LANES=9 gives 1.
- Back-to-back: start=1 during DONE is accepted at that edge. The throughput is one result per BEATS+1 cycles, and done never stays high for two consecutive cycles.
- P keeps its value through IDLE and through the following RUN. It changes only at a done edge or on reset.

## Test plan
- NBITS=16, TAPS=9, LANES=1, SHIFT=0, SAT=1; inputs 1..9, weights all 1 → done pulses 9 cycles after accept with P=45. P stays 45 afterwards. Changing the inputs during RUN does not alter the result.
- Same vectors, LANES=4, covering the partial last beat → P=45, done 3 cycles after accept. Repeat with LANES=9 → done 1 cycle after accept.
- Saturation: all inputs 32767 and all weights 32767:
  - SAT=1 → P=32767.
  - SAT=0 → P=9, the low 16 bits of 0x23FF70009.
  - Inputs -32768, weights 32767, SAT=1 → P=-32768.
- Rounding, SHIFT=2:
  - Accumulator 45 (first vector set) → P=11.
  - Negate the weights (accumulator -45) → P=-11.
  - Accumulator 6 → P=2.
- Handshake:
  - start held high continuously → results every BEATS+1 cycles, with done a single-cycle pulse each time.
  - A start pulse mid-RUN is ignored; ready=0 and busy=1 throughout RUN.
- Reset: assert reset=0 at beat 4 of a LANES=1 run → P=0, done=0, ready=1 immediately. After release, no done pulse appears, and a fresh start yields a correct P.
